// File: rtl/irrigation_timer_ctrl.sv
// Irrigation watering timer: two-digit BCD countdown driving a valve.
// Optional pause/resume is compiled in with macro TIMER_PAUSE_EN.
module irrigation_timer_ctrl (
  input  logic       clockin,
  input  logic       reset,
  input  logic       tick,
  input  logic       botao,
  input  logic [3:0] preset_u,
  input  logic [3:0] preset_d,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] Q_u,
  output logic [3:0] Q_d,
  output logic       valve,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;
  logic [3:0] r_q_u;
  logic [3:0] r_q_d;
  logic [3:0] w_q_u_nx;
  logic [3:0] w_q_d_nx;
  logic       r_valve;
  logic       w_valve_nx;
  logic       r_done;
  logic       w_done_nx;

  logic [3:0] w_ld_u;
  logic [3:0] w_ld_d;
  logic [3:0] w_dec_u;
  logic [3:0] w_dec_d;
  logic       w_dec_zero;
  logic       w_cnt_zero;
  logic       w_pause;

  // Digits above 9 are saturated so the count stays valid BCD.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] x);
    return (x > 4'd9) ? 4'd9 : x;
  endfunction

`ifdef TIMER_PAUSE_EN
  assign w_pause = pause;
`else
  logic w_unused_pause;
  assign w_unused_pause = pause;
  assign w_pause = 1'b0;
`endif

  assign w_ld_u = bcd_clamp(preset_u);
  assign w_ld_d = bcd_clamp(preset_d);
  assign w_cnt_zero = (r_q_u == 4'd0) && (r_q_d == 4'd0);

  // BCD decrement with borrow; floor at 00 so the count never wraps.
  always_comb begin
    w_dec_u = r_q_u;
    w_dec_d = r_q_d;
    if (!w_cnt_zero) begin
      if (r_q_u == 4'd0) begin
        w_dec_u = 4'd9;
        w_dec_d = r_q_d - 4'd1;
      end else begin
        w_dec_u = r_q_u - 4'd1;
      end
    end
  end

  assign w_dec_zero = (w_dec_u == 4'd0) && (w_dec_d == 4'd0);

  // Next-state and next-output decode; botao outranks everything.
  always_comb begin
    w_state_nx = r_state;
    w_q_u_nx   = r_q_u;
    w_q_d_nx   = r_q_d;
    w_valve_nx = r_valve;
    w_done_nx  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_valve_nx = 1'b0;
        if (botao) begin
          w_q_u_nx = w_ld_u;
          w_q_d_nx = w_ld_d;
        end else if (start && !w_cnt_zero) begin
          w_state_nx = S_RUN;
          w_valve_nx = 1'b1;
        end
      end
      S_RUN: begin
        w_valve_nx = 1'b1;
        if (botao) begin
          w_state_nx = S_IDLE;
          w_valve_nx = 1'b0;
          w_q_u_nx   = w_ld_u;
          w_q_d_nx   = w_ld_d;
        end else if (w_pause) begin
          w_state_nx = S_PAUSE;
          w_valve_nx = 1'b0;
        end else if (tick) begin
          w_q_u_nx = w_dec_u;
          w_q_d_nx = w_dec_d;
          if (w_dec_zero) begin
            w_state_nx = S_DONE;
            w_valve_nx = 1'b0;
            w_done_nx  = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        w_valve_nx = 1'b0;
`ifdef TIMER_PAUSE_EN
        if (botao) begin
          w_state_nx = S_IDLE;
          w_q_u_nx   = w_ld_u;
          w_q_d_nx   = w_ld_d;
        end else if (w_pause) begin
          w_state_nx = S_RUN;
          w_valve_nx = 1'b1;
        end
`else
        w_state_nx = S_IDLE;
`endif
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_valve_nx = 1'b0;
        w_q_u_nx   = 4'd0;
        w_q_d_nx   = 4'd0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_valve_nx = 1'b0;
      end
    endcase
  end

  // State and all outputs registered; reset closes the valve at once.
  always_ff @(posedge clockin or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_q_u   <= 4'd0;
      r_q_d   <= 4'd0;
      r_valve <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_q_u   <= w_q_u_nx;
      r_q_d   <= w_q_d_nx;
      r_valve <= w_valve_nx;
      r_done  <= w_done_nx;
    end
  end

  assign Q_u   = r_q_u;
  assign Q_d   = r_q_d;
  assign valve = r_valve;
  assign done  = r_done;
  assign state = r_state;

endmodule

// File: tb/tb_irrigation_timer_ctrl.sv
// Scoreboard bench for irrigation_timer_ctrl.
// A decimal reference model predicts each cycle's registered outputs.
module tb_irrigation_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       botao;
  logic [3:0] pu;
  logic [3:0] pd;
  logic       start;
  logic       pause;
  logic [3:0] q_u;
  logic [3:0] q_d;
  logic       valve;
  logic       done;
  logic [1:0] state;

  irrigation_timer_ctrl dut (
    .clockin (clk),
    .reset   (rst),
    .tick    (tick),
    .botao   (botao),
    .preset_u(pu),
    .preset_d(pd),
    .start   (start),
    .pause   (pause),
    .Q_u     (q_u),
    .Q_d     (q_d),
    .valve   (valve),
    .done    (done),
    .state   (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] qd;
    logic [3:0] qu;
    logic       v;
    logic       d;
    logic [1:0] st;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done = 0;

  int   m_cnt;
  int   m_st;
  bit   m_valve;
  bit   m_done;

`ifdef TIMER_PAUSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int clamp9(input logic [3:0] x);
    return (x > 4'd9) ? 9 : int'(x);
  endfunction

  function automatic void model_reset();
    m_cnt = 0;
    m_st = 0;
    m_valve = 0;
    m_done = 0;
  endfunction

  function automatic void model_step();
    int ld;
    ld = clamp9(pd) * 10 + clamp9(pu);
    m_done = 0;
    case (m_st)
      0: begin
        if (botao) m_cnt = ld;
        else if (start && m_cnt != 0) begin
          m_st = 1;
          m_valve = 1;
        end
      end
      1: begin
        if (botao) begin
          m_st = 0; m_valve = 0; m_cnt = ld;
        end else if (PEN && pause) begin
          m_st = 2; m_valve = 0;
        end else if (tick) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_st = 3; m_valve = 0; m_done = 1;
          end
        end
      end
      2: begin
        if (botao) begin
          m_st = 0; m_cnt = ld;
        end else if (pause) begin
          m_st = 1; m_valve = 1;
        end
      end
      default: m_st = 0;
    endcase
  endfunction

  task automatic step(input bit b, input bit s,
                      input bit p, input bit t);
    exp_t e;
    exp_t o;
    botao = b;
    start = s;
    pause = p;
    tick  = t;
    model_step();
    e.qd = 4'(m_cnt / 10);
    e.qu = 4'(m_cnt % 10);
    e.v  = m_valve;
    e.d  = m_done;
    e.st = 2'(m_st);
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    botao = 0; start = 0; pause = 0; tick = 0;
    if (done) n_done++;
    if (q_exp.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      o = q_exp.pop_front();
      check("q_d", q_d, o.qd);
      check("q_u", q_u, o.qu);
      check("valve", valve, o.v);
      check("done", done, o.d);
      check("state", state, o.st);
    end
  endtask

  task automatic load(input int d, input int u);
    pd = 4'(d);
    pu = 4'(u);
    step(1, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
  endtask

  initial begin
    rst = 1; tick = 0; botao = 0;
    start = 0; pause = 0; pu = 0; pd = 0;
    model_reset();
    #12;
    check("rst_qu", q_u, 0);
    check("rst_qd", q_d, 0);
    check("rst_valve", valve, 0);
    check("rst_st", state, 0);
    #2 rst = 0;
    @(posedge clk);
    #1;

    load(1, 2);
    check("ld12", {q_d, q_u}, 8'h12);
    step(0, 1, 0, 0);
    check("run_valve", valve, 1);
    n_done = 0;
    ticks(11);
    check("at01", {q_d, q_u}, 8'h01);
    ticks(1);
    step(0, 0, 0, 0);
    check("end00", {q_d, q_u}, 8'h00);
    check("one_done", n_done, 1);
    check("end_idle", state, 0);

    load(1, 0);
    step(0, 1, 0, 0);
    ticks(1);
    check("borrow", {q_d, q_u}, 8'h09);
    load(4'hA, 4'hF);
    check("clamp99", {q_d, q_u}, 8'h99);

    load(0, 0);
    n_done = 0;
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("zero_idle", state, 0);
    check("zero_valve", valve, 0);
    check("zero_nodone", n_done, 0);

    load(3, 0);
    step(0, 1, 0, 0);
    ticks(2);
    pd = 0; pu = 5;
    step(1, 0, 1, 1);
    check("abort_cnt", {q_d, q_u}, 8'h05);
    check("abort_st", state, 0);
    check("abort_nodone", n_done, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    check("start_in_run", state, 1);

    load(2, 0);
    step(0, 1, 0, 0);
    ticks(3);
    n_done = 0;
    step(0, 0, 1, 0);
    ticks(5);
    check("paused_cnt", {q_d, q_u}, PEN ? 8'h17 : 8'h12);
    step(0, 0, 1, 0);
    ticks(17);
    check("pause_end", {q_d, q_u}, 8'h00);
    check("pause_done", n_done, 1);

    load(4, 5);
    step(0, 1, 0, 0);
    ticks(2);
    #3;
    rst = 1;
    #1;
    check("arst_valve", valve, 0);
    check("arst_cnt", {q_d, q_u}, 8'h00);
    check("arst_st", state, 0);
    model_reset();
    #2 rst = 0;
    @(posedge clk);
    #1;
    load(0, 3);
    step(0, 1, 0, 0);
    ticks(3);
    step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irrigation_timer_ctrl.md
IRRIGATION_TIMER_CTRL -- requirements
Module: irrigation_timer_ctrl

Interface
REQ-001 The block SHALL have port `clockin`, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port `tick`, input, 1 bit: one-`clockin`-cycle timebase pulse, 1 per second.
REQ-004 The block SHALL have port `botao`, input, 1 bit: load-preset request (level, sampled per cycle).
REQ-005 The block SHALL have port `preset_u`, input, 4 bits: BCD units digit of the watering duration.
REQ-006 The block SHALL have port `preset_d`, input, 4 bits: BCD tens digit of the watering duration.
REQ-007 The block SHALL have port `start`, input, 1 bit: start-watering request (level, sampled per cycle).
REQ-008 The block SHALL have port `pause`, input, 1 bit: pause/resume request (one-cycle pulse).
REQ-009 The block SHALL have port `Q_u`, output, 4 bits: remaining-time units digit, BCD.
REQ-010 The block SHALL have port `Q_d`, output, 4 bits: remaining-time tens digit, BCD.
REQ-011 The block SHALL have port `valve`, output, 1 bit: irrigation valve drive, 1 = open.
REQ-012 The block SHALL have port `done`, output, 1 bit: one-cycle pulse at end of watering.
REQ-013 The block SHALL have port `state`, output, 2 bits: FSM state code, IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have exactly the states IDLE, RUN, PAUSE and DONE.
REQ-016 In IDLE, `botao`=1 SHALL load {`Q_d`,`Q_u`} from the presets on the next edge.
REQ-017 A preset digit greater than 9 SHALL be loaded as 9.
REQ-018 In IDLE, `start`=1 with count not equal to 00 SHALL enter RUN on the next edge, with `valve`=1 from that edge.
REQ-019 In IDLE, `start`=1 with count equal to 00 SHALL be ignored.
REQ-020 In RUN, each `tick` SHALL decrement the two-digit BCD count by one, visible one cycle after `tick` is sampled.
REQ-021 On a RUN decrement, units 0 SHALL become 9 with a borrow from tens; units 1-9 SHALL decrement without borrow.
REQ-022 The count SHALL never leave the range 00-99 or hold a non-BCD digit.
REQ-023 In RUN, a `tick` that makes the count 00 SHALL enter DONE on the same edge, with `valve`=0 from that edge.
REQ-024 DONE SHALL last exactly one cycle, with `done`=1 during it, then enter IDLE; the count SHALL stay 00.
REQ-025 `botao`=1 in RUN or PAUSE SHALL abort: next state IDLE, `valve`=0, preset loaded, no `done` pulse.
REQ-026 `botao` SHALL take priority over `tick`, `start` and `pause` in the same cycle.
REQ-027 `tick` in IDLE, PAUSE or DONE SHALL NOT change the count.
REQ-028 `start` outside IDLE SHALL be ignored.

Reset
REQ-029 `reset`=1 SHALL immediately, asynchronously, force: state IDLE, `Q_u`=0, `Q_d`=0, `valve`=0, `done`=0.
REQ-030 `reset` asserted mid-RUN SHALL close the valve without a clock edge.
REQ-031 After `reset` deassertion, the block SHALL resume normal operation on the first `clockin` edge.

Configuration
REQ-032 With macro TIMER_PAUSE_EN defined, `pause` in RUN SHALL enter PAUSE (`valve`=0, count frozen).
REQ-033 With TIMER_PAUSE_EN defined, `pause` in PAUSE SHALL return to RUN (`valve`=1), resuming from the frozen count.
REQ-034 With TIMER_PAUSE_EN defined, `pause` and `tick` in the same RUN cycle SHALL give PAUSE with the count unchanged.
REQ-035 Without TIMER_PAUSE_EN, `pause` SHALL be ignored, the PAUSE state SHALL be unreachable, and `state` SHALL never read 10.

Verification
REQ-036 Reset, load 12 via `botao`, `start`, 12 ticks -> count 11,10,09,...,01,00; `valve` high exactly from start through the 12th tick edge; `done` one cycle; state returns to IDLE.
REQ-037 Load 10, run, 1 tick -> count 09 (borrow); load 0xF/0xA presets -> count 99.
REQ-038 Load 00, `start` -> state stays IDLE, `valve`=0, no `done`.
REQ-039 Run from 30, assert `botao` with presets 05 on the same cycle as `tick` -> IDLE, count 05, `valve`=0, no `done`.
REQ-040 With TIMER_PAUSE_EN: run from 20, 3 ticks, `pause`, 5 ticks, `pause`, 17 ticks -> count holds 17 while paused, reaches 00, single `done`. Without TIMER_PAUSE_EN: `pause` has no effect.
REQ-041 Assert `reset` mid-RUN between clock edges -> `valve`, `Q_u` and `Q_d` go to 0 immediately.
